rv32_mod_mem_port_arbiter: RTL and testbench

//  Shares the single external memory port between the instruction-fetch unit (port 0)
//  and the load/store unit (port 1) of the rv32imc_ss hart. Captures each port's

---
 rtl/rv32_mod_mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_rv32_mod_mem_port_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mod_mem_port_arbiter.sv
// Shares the single external memory port between instruction fetch (port 0) and the LSU
// (port 1); one transaction in flight, with a watchdog against silent slaves.
module rv32_mod_mem_port_arbiter #(
    parameter int unsigned TIMEOUT_W = 8,
    parameter bit          RR_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_do,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_di,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_do,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_di,
    output logic        dext_req,
    output logic        dext_wr,
    output logic [3:0]  dext_be,
    output logic [31:0] dext_addr,
    output logic [31:0] dext_do,
    input  logic        dext_ack,
    input  logic        dext_err,
    input  logic [31:0] dext_di,
    output logic        protocol_err
);
    typedef struct packed {
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_t;

    localparam logic [TIMEOUT_W-1:0] CntMax = {TIMEOUT_W{1'b1}};

    state_t               state_q, state_d;
    logic [1:0]           pend_q, pend_d;
    cmd_t [1:0]           pcmd_q, pcmd_d;
    logic                 owner_q, owner_d;
    logic                 last_q, last_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 dreq_q, dreq_d;
    cmd_t                 dcmd_q, dcmd_d;
    logic [1:0]           ack_q, ack_d;
    logic [1:0]           err_q, err_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 perr_q, perr_d;

    logic [1:0]           in_req, active, accept, cand;
    cmd_t [1:0]           in_cmd;
    logic                 win, resp, tmo;
    logic [TIMEOUT_W-1:0] cnt_inc;

    assign in_req    = {m1_req, m0_req};
    assign in_cmd[0] = {m0_wr, m0_be, m0_addr, m0_do};
    assign in_cmd[1] = {m1_wr, m1_be, m1_addr, m1_do};
    assign active    = (state_q == StIdle) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
    // A port that is already queued or on the bus may not post a second request.
    assign accept    = in_req & ~pend_q & ~active;
    assign cand      = pend_q | accept;
    assign win       = (&cand) ? (RR_EN ? ~last_q : 1'b1) : cand[1];
    assign resp      = dext_ack | dext_err;
    assign cnt_inc   = cnt_q + 1'b1;
    assign tmo       = (state_q == StWait) && !resp && (cnt_inc == CntMax);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | accept;
        pcmd_d  = pcmd_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        dreq_d  = 1'b0;
        dcmd_d  = dcmd_q;
        ack_d   = 2'b00;
        err_d   = 2'b00;
        rdata_d = '0;
        perr_d  = |(in_req & ~accept);
        for (int n = 0; n < 2; n++) begin
            if (accept[n]) pcmd_d[n] = in_cmd[n];
        end
        case (state_q)
            StIdle: begin
                if (|cand) begin
                    pend_d[win] = 1'b0;
                    dcmd_d      = pend_q[win] ? pcmd_q[win] : in_cmd[win];
                    dreq_d      = 1'b1;
                    owner_d     = win;
                    last_d      = win;
                    state_d     = StIssue;
                end
            end
            StIssue, StWait: begin
                if (resp || tmo) begin
                    state_d = StIdle;
                    if (dext_err || tmo) begin
                        err_d[owner_q] = 1'b1;
                    end else begin
                        ack_d[owner_q] = 1'b1;
                        rdata_d        = dcmd_q.wr ? 32'h0 : dext_di;
                    end
                end else if (state_q == StIssue) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pend_q  <= 2'b00;
            pcmd_q  <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            dreq_q  <= 1'b0;
            dcmd_q  <= '0;
            ack_q   <= 2'b00;
            err_q   <= 2'b00;
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            pcmd_q  <= pcmd_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            dreq_q  <= dreq_d;
            dcmd_q  <= dcmd_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
        end
    end

    assign m0_ack       = ack_q[0];
    assign m0_err       = err_q[0];
    assign m0_di        = ack_q[0] ? rdata_q : 32'h0;
    assign m1_ack       = ack_q[1];
    assign m1_err       = err_q[1];
    assign m1_di        = ack_q[1] ? rdata_q : 32'h0;
    assign dext_req     = dreq_q;
    assign dext_wr      = dcmd_q.wr;
    assign dext_be      = dcmd_q.be;
    assign dext_addr    = dcmd_q.addr;
    assign dext_do      = dcmd_q.wdata;
    assign protocol_err = perr_q;
endmodule

// File: tb/tb_rv32_mod_mem_port_arbiter.sv
// Bench for rv32_mod_mem_port_arbiter: directed scenarios and random traffic checked each cycle
// against a transaction-level model; a second fixed-priority instance checks grant order.
module tb_rv32_mod_mem_port_arbiter;
    localparam int TW  = 4;
    localparam int TMO = (1 << TW) - 1;

    typedef struct packed {
        bit        wr;
        bit [3:0]  be;
        bit [31:0] addr;
        bit [31:0] wd;
    } cmd_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
    logic [3:0] m0_be = 4'h0, m1_be = 4'h0;
    logic [31:0] m0_addr = 32'h0, m0_do = 32'h0, m1_addr = 32'h0, m1_do = 32'h0;
    logic dext_ack = 1'b0, dext_err = 1'b0;
    logic [31:0] dext_di = 32'h0;
    logic m0_ack, m0_err, m1_ack, m1_err, dext_req, dext_wr, protocol_err;
    logic [31:0] m0_di, m1_di, dext_addr, dext_do;
    logic [3:0] dext_be;

    logic b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_dext_req, b_dext_wr, b_protocol_err;
    logic [31:0] b_m0_di, b_m1_di, b_dext_addr, b_dext_do;
    logic [3:0] b_dext_be;
    logic b_dext_ack, b_dext_err;
    logic [31:0] b_dext_di;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32_mod_mem_port_arbiter #(.TIMEOUT_W(TW), .RR_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_be(m0_be), .m0_addr(m0_addr), .m0_do(m0_do),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_di(m0_di),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_be(m1_be), .m1_addr(m1_addr), .m1_do(m1_do),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_di(m1_di),
        .dext_req(dext_req), .dext_wr(dext_wr), .dext_be(dext_be), .dext_addr(dext_addr),
        .dext_do(dext_do), .dext_ack(dext_ack), .dext_err(dext_err), .dext_di(dext_di),
        .protocol_err(protocol_err)
    );

    // Fixed-priority instance with a slave that answers in the issue cycle.
    assign b_dext_ack = b_dext_req;
    assign b_dext_err = 1'b0;
    assign b_dext_di  = 32'hCAFE0000;

    rv32_mod_mem_port_arbiter #(.TIMEOUT_W(TW), .RR_EN(1'b0)) dut_fixed (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_be(m0_be), .m0_addr(m0_addr), .m0_do(m0_do),
        .m0_ack(b_m0_ack), .m0_err(b_m0_err), .m0_di(b_m0_di),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_be(m1_be), .m1_addr(m1_addr), .m1_do(m1_do),
        .m1_ack(b_m1_ack), .m1_err(b_m1_err), .m1_di(b_m1_di),
        .dext_req(b_dext_req), .dext_wr(b_dext_wr), .dext_be(b_dext_be),
        .dext_addr(b_dext_addr), .dext_do(b_dext_do), .dext_ack(b_dext_ack),
        .dext_err(b_dext_err), .dext_di(b_dext_di), .protocol_err(b_protocol_err)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: queued requests per port plus one bus transaction with an age.
    bit [1:0]  m_pend = 2'b00;
    cmd_t      m_pq[2];
    bit        m_busy = 1'b0, m_owner = 1'b0, m_last = 1'b0;
    int        m_age = 0;
    cmd_t      m_cur = '0;
    bit [1:0]  e_ack = 2'b00, e_err = 2'b00;
    bit [31:0] e_di[2];
    bit        e_dreq = 1'b0, e_perr = 1'b0;

    task automatic model_step();
        bit [1:0] req;
        cmd_t     in_c[2];
        bit       was_busy, w;
        e_ack = 2'b00; e_err = 2'b00; e_di[0] = 32'h0; e_di[1] = 32'h0;
        e_dreq = 1'b0; e_perr = 1'b0;
        if (reset) begin
            m_pend = 2'b00; m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b0; m_age = 0;
            m_cur = '0;
            return;
        end
        req = {m1_req, m0_req};
        in_c[0] = {m0_wr, m0_be, m0_addr, m0_do};
        in_c[1] = {m1_wr, m1_be, m1_addr, m1_do};
        was_busy = m_busy;
        for (int n = 0; n < 2; n++) begin
            if (req[n]) begin
                if (m_pend[n] || (m_busy && m_owner == n[0])) e_perr = 1'b1;
                else begin
                    m_pend[n] = 1'b1;
                    m_pq[n]   = in_c[n];
                end
            end
        end
        if (was_busy) begin
            if (dext_err || (!dext_ack && m_age == TMO)) begin
                e_err[m_owner] = 1'b1;
                m_busy = 1'b0;
            end else if (dext_ack) begin
                e_ack[m_owner] = 1'b1;
                e_di[m_owner]  = m_cur.wr ? 32'h0 : dext_di;
                m_busy = 1'b0;
            end else begin
                m_age++;
            end
        end else if (m_pend != 2'b00) begin
            w = (m_pend == 2'b11) ? ~m_last : m_pend[1];
            m_pend[w] = 1'b0;
            m_cur = m_pq[w];
            m_busy = 1'b1; m_age = 0; m_owner = w; m_last = w;
            e_dreq = 1'b1;
        end
    endtask

    initial begin
        logic [138:0] got_v, exp_v;
        forever begin
            @(posedge clk or posedge reset);
            model_step();
            #2;
            got_v = {m0_ack, m0_err, m0_di, m1_ack, m1_err, m1_di, dext_req, dext_wr, dext_be,
                     dext_addr, dext_do, protocol_err};
            exp_v = {e_ack[0], e_err[0], e_di[0], e_ack[1], e_err[1], e_di[1], e_dreq, m_cur,
                     e_perr};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL model_compare @%0t: dut %h model %h", $time, got_v, exp_v);
            end
        end
    end

    // Slave for the round-robin instance: answers sl_lat cycles after dext_req, -1 = silent.
    int          rem = -1, sl_lat = 0;
    bit          sl_err = 1'b0, rnd_mode = 1'b0;
    logic [31:0] sl_di = 32'h0;

    task automatic step();
        @(negedge clk);
        dext_ack = 1'b0; dext_err = 1'b0; dext_di = 32'h0;
        if (reset) begin
            rem = -1;
        end else begin
            if (dext_req) begin
                if (rnd_mode) begin
                    sl_lat = int'($urandom_range(0, 5));
                    if (sl_lat == 5) sl_lat = -1;
                    sl_err = ($urandom_range(4) == 0);
                    sl_di  = $urandom;
                end
                rem = sl_lat;
            end
            if (rem == 0) begin
                if (sl_err) dext_err = 1'b1;
                else dext_ack = 1'b1;
                dext_di = sl_di;
            end
            if (rem >= 0) rem--;
            if (rnd_mode && $urandom_range(31) == 0) begin
                dext_ack = 1'($urandom_range(1));
                dext_err = ($urandom_range(3) == 0);
                dext_di  = $urandom;
            end
        end
    endtask

    task automatic req_port(input int p, input bit wr, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] d);
        if (p == 0) begin
            m0_req = 1'b1; m0_wr = wr; m0_be = be; m0_addr = addr; m0_do = d;
        end else begin
            m1_req = 1'b1; m1_wr = wr; m1_be = be; m1_addr = addr; m1_do = d;
        end
    endtask

    task automatic clr_req();
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic idle(input int n);
        clr_req();
        repeat (n) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, np, nd;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("reset m-side", {m0_ack, m0_err, m0_di, m1_ack, m1_err, m1_di, protocol_err}, 0);
        check("reset bus", {dext_req, dext_wr, dext_be, dext_addr, dext_do}, 0);

        // Port 1 read, slave answers two cycles after dext_req.
        sl_lat = 2; sl_err = 1'b0; sl_di = 32'hDEADBEEF;
        req_port(1, 1'b0, 4'hF, 32'h100, 32'h0);
        step(); clr_req();
        check("t1 issue", {dext_req, dext_wr, dext_be, dext_addr}, {1'b1, 1'b0, 4'hF, 32'h100});
        step();
        check("t1 req one cycle", dext_req, 1'b0);
        step(); step();
        check("t1 m1 ack", {m1_ack, m1_err, m1_di}, {1'b1, 1'b0, 32'hDEADBEEF});
        check("t1 m0 quiet", {m0_ack, m0_err, m0_di}, 0);
        step();
        check("t1 ack pulse", m1_ack, 1'b0);
        idle(2);

        // Port 0 write that the slave rejects.
        sl_lat = 1; sl_err = 1'b1;
        req_port(0, 1'b1, 4'b0011, 32'h200, 32'h12345678);
        step(); clr_req();
        check("t3 issue", {dext_req, dext_wr, dext_be, dext_addr, dext_do},
              {1'b1, 1'b1, 4'b0011, 32'h200, 32'h12345678});
        step(); step();
        check("t3 m0 err", {m0_ack, m0_err, m0_di}, {1'b0, 1'b1, 32'h0});
        idle(3);

        // Simultaneous requests after a port 0 grant.
        sl_lat = 1; sl_err = 1'b0; sl_di = 32'h11112222;
        req_port(0, 1'b0, 4'hF, 32'h300, 32'h0);
        req_port(1, 1'b0, 4'hF, 32'h400, 32'h0);
        step(); clr_req();
        check("t2 rr first p1", {dext_req, dext_addr}, {1'b1, 32'h400});
        check("t2 fixed first p1", {b_dext_req, b_dext_wr, b_dext_be, b_dext_addr, b_dext_do},
              {1'b1, 1'b0, 4'hF, 32'h400, 32'h0});
        step();
        check("t2 fixed p1 done", {b_m0_ack, b_m0_err, b_m0_di, b_m1_ack, b_m1_err, b_m1_di,
              b_protocol_err}, {1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hCAFE0000, 1'b0});
        step();
        check("t2 rr p1 ack", {m1_ack, m1_di, dext_req}, {1'b1, 32'h11112222, 1'b0});
        step();
        check("t2 rr p0 follows", {dext_req, dext_addr}, {1'b1, 32'h300});
        idle(6);
        req_port(1, 1'b0, 4'hF, 32'h410, 32'h0);
        step();
        idle(6);
        req_port(0, 1'b0, 4'hF, 32'h300, 32'h0);
        req_port(1, 1'b0, 4'hF, 32'h400, 32'h0);
        step(); clr_req();
        check("t2 rr alternates p0", {dext_req, dext_addr}, {1'b1, 32'h300});
        check("t2 fixed p1 again", {b_dext_req, b_dext_addr}, {1'b1, 32'h400});
        idle(8);

        // Silent slave: timeout, late ack ignored, next request served.
        sl_lat = -1;
        req_port(1, 1'b0, 4'hF, 32'h600, 32'h0);
        step(); clr_req();
        n = 1;
        while (!m1_err && n < 40) begin
            step();
            n++;
        end
        check("t4 timeout latency", n, 17);
        check("t4 timeout err", {m1_ack, m1_err, m1_di}, {1'b0, 1'b1, 32'h0});
        dext_ack = 1'b1; dext_di = 32'h00000BAD;
        sl_lat = 0; sl_err = 1'b0; sl_di = 32'h5A5A5A5A;
        req_port(0, 1'b0, 4'hF, 32'h500, 32'h0);
        step(); clr_req();
        check("t4 late ack ignored", {m1_ack, m0_ack}, 0);
        check("t4 next issue", {dext_req, dext_addr}, {1'b1, 32'h500});
        step();
        check("t4 p0 ack", {m0_ack, m0_di, m1_ack, m1_err}, {1'b1, 32'h5A5A5A5A, 1'b0, 1'b0});
        idle(3);

        // Re-request while active.
        sl_lat = 3;
        req_port(1, 1'b0, 4'hF, 32'h700, 32'h0);
        step(); clr_req();
        check("t5 issue", dext_req, 1'b1);
        step();
        req_port(1, 1'b0, 4'hF, 32'h704, 32'h0);
        np = 0; nd = 0;
        for (int i = 0; i < 8; i++) begin
            step(); clr_req();
            if (protocol_err) np++;
            if (dext_req) nd++;
        end
        check("t5 protocol_err pulses", np, 1);
        check("t5 no extra dext_req", nd, 0);
        idle(2);

        // Reset while waiting on a silent slave.
        sl_lat = -1;
        req_port(1, 1'b0, 4'hF, 32'h800, 32'h0);
        step(); clr_req();
        repeat (3) step();
        reset = 1'b1;
        #1;
        check("t6 reset m-side", {m0_ack, m0_err, m0_di, m1_ack, m1_err, m1_di, protocol_err}, 0);
        check("t6 reset bus", {dext_req, dext_wr, dext_be, dext_addr, dext_do}, 0);
        step(); step();
        reset = 1'b0;
        dext_ack = 1'b1; dext_di = 32'h00001234;
        step();
        check("t6 no ack after reset", {m0_ack, m1_ack, m0_err, m1_err}, 0);
        step();
        check("t6 still quiet", {m0_ack, m1_ack, m0_err, m1_err}, 0);
        idle(2);

        // Random traffic, checked cycle by cycle against the model.
        rnd_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (i == 1500) reset = 1'b1;
            if (i == 1503) reset = 1'b0;
            m0_req  = ($urandom_range(3) == 0);
            m0_wr   = 1'($urandom_range(1));
            m0_be   = 4'($urandom);
            m0_addr = $urandom;
            m0_do   = $urandom;
            m1_req  = ($urandom_range(3) == 0);
            m1_wr   = 1'($urandom_range(1));
            m1_be   = 4'($urandom);
            m1_addr = $urandom;
            m1_do   = $urandom;
        end
        rnd_mode = 1'b0;
        idle(24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
